decode_inst_buffer: RTL
=======================

# decode_inst_buffer

Multi-wide circular instruction queue between decode and rename. Accepts up to `IN_WIDTH` decoded packets per cycle and presents up to `OUT_WIDTH` oldest packets per cycle to rename. It drives `instBufferReady_i` and the lane packets that rename consumes. It is flushed on pipeline recovery and applies back-pressure to decode when it cannot accept a full group.

## Interface
Parameters:
- `DEPTH`, 32: entries; power of two, at least `IN_WIDTH + OUT_WIDTH`.
- `IN_WIDTH`, 4: enqueue lanes (fetch/decode width).
- `OUT_WIDTH`, 4: dequeue lanes (`DISPATCH_WIDTH`).
- `PKT_W`, 128: payload bits per packet (packed `renPkt` minus valid).

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high. One clock; all state is sampled on rising `clk`.
- `flush_i` input 1: recovery flush (`recoverFlag`).
- `decValid_i` input `IN_WIDTH`: per-lane valid. Valid lanes are contiguous from lane 0.
- `decPacket_i` input `IN_WIDTH` x `PKT_W`: decoded packets.
- `stall_i` input 1: rename not consuming this cycle.
- `stallFetch_o` output 1: buffer cannot guarantee `IN_WIDTH` free slots. While it is high, decode holds its input.
- `instBufferReady_o` output 1: at least one valid output lane.
- `outValid_o` output `OUT_WIDTH`: per-lane valid, contiguous from lane 0.
- `outPacket_o` output `OUT_WIDTH` x `PKT_W`: entries head..head+`OUT_WIDTH`-1, oldest in lane 0.

## Operation
State:
- `head` and `tail` pointers, log2(`DEPTH`) bits, wrap modulo `DEPTH`.
- `count`, log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- Storage RAM.

Combinational outputs (all computed from the current registered state):
- `stallFetch_o` = `count > DEPTH - IN_WIDTH`. It uses `count` before this cycle's dequeue, so the check is deliberately conservative.
- `nOut` = min(`count`, `OUT_WIDTH`).
- `outValid_o[i]` = (`i < nOut`) & ~`flush_i`.
- `instBufferReady_o` = `outValid_o[0]`.
- `outPacket_o[i]` = `mem[(head+i) mod DEPTH]` regardless of validity.

Per-cycle counts:
- `nEnq` = popcount(`decValid_i`) when `~stallFetch_o & ~flush_i`, else 0.
- `nDeq` = `nOut` when `~stall_i & ~flush_i`, else 0. Rename accepts all presented valid lanes at once; there is no partial acceptance.

Register updates:
- Enqueue writes lane `i` to `mem[(tail+i) mod DEPTH]` for `i < nEnq`.
- `tail += nEnq`, `head += nDeq`, `count += nEnq - nDeq`.
- Enqueue and dequeue occur together in one cycle. Enqueued entries are never visible on the outputs in the same cycle.
- Priority: `reset` > `flush_i` > enqueue/dequeue.
- On `flush_i`, `head`, `tail` and `count` go to 0 at the next edge. All inputs are ignored that cycle. RAM contents are not cleared.

Boundary conditions:
- Full (`count == DEPTH`): `stallFetch_o` is high. Dequeue is still allowed.
- Empty: all `outValid_o` are 0 and `instBufferReady_o` is 0.
- Wrap-around: lane indices wrap modulo `DEPTH` on both write and read.
- Non-contiguous `decValid_i` is illegal. The design counts only the set bits and writes the lowest lanes.

## Timing
- Reset values: `head` = `tail` = `count` = 0, `stallFetch_o` = 0, `instBufferReady_o` = 0, `outValid_o` = 0. `outPacket_o` is don't-care.
- Enqueue-to-output latency: 1 cycle. A packet accepted at edge N is presentable in cycle N+1.
- Handshake: dequeue completes at the edge that ends a cycle where `instBufferReady_o & ~stall_i` holds.
- Flush: effective at the next edge. Outputs are already invalid during the flush cycle.
- A reset mid-operation discards all entries at the next edge.

## Configuration
- `IBUFF_PERF_MON_EN` defined:
  - Adds output `ibuffCnt_o` (log2(`DEPTH`)+1 bits), which equals `count`.
  - Adds output `fetchStallCycles_o` (32 bits), which increments on every cycle with `stallFetch_o` high. It saturates at all-ones and clears on `reset`. Flush does not clear it.
- `IBUFF_PERF_MON_EN` undefined: neither port nor counter exists, and functional behaviour is identical.

## Test plan
- Reset, then idle: `instBufferReady_o` = 0 and `outValid_o` = 0 for 3 cycles. With the macro defined, `ibuffCnt_o` = 0.
- Enqueue 3 valid lanes (`decValid_i` = 0111) with `stall_i` = 0: in the next cycle, `outValid_o` = 0111 with packets in order. Those entries are consumed at the following edge and `count` returns to 0.
- Fill: enqueue 4 per cycle with `stall_i` = 1. After 8 cycles `count` = 32 and `stallFetch_o` = 1, and it is already 1 from `count` = 29. Held input is not written.
- Wrap-around: with `head` = 30 and `count` = 4, `outPacket_o` lanes come from entries 30, 31, 0, 1 in order. Dequeue sets `head` = 2.
- Flush with `count` = 10 while enqueueing 4 and `stall_i` = 0: `outValid_o` = 0 during that cycle. Next cycle `count` = 0 and no packet is lost to a dequeue or written by an enqueue.
- With `count` = 6, hold `stall_i` = 1 for 5 cycles, then release: outputs are stable and identical across the stall. The first cycle after release dequeues 4, then 2 the next cycle.

Source files
------------

// File: rtl/decode_inst_buffer_if.sv
// Decode-to-rename handshake bundle for the instruction buffer.
// The master modport is the decode/rename side and the slave modport is the buffer.
interface decode_inst_buffer_if #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int PKT_W     = 128
);
    logic [IN_WIDTH-1:0]             decValid_i;
    logic [IN_WIDTH-1:0][PKT_W-1:0]  decPacket_i;
    logic                            stall_i;
    logic                            stallFetch_o;
    logic                            instBufferReady_o;
    logic [OUT_WIDTH-1:0]            outValid_o;
    logic [OUT_WIDTH-1:0][PKT_W-1:0] outPacket_o;

    modport master (
        output decValid_i, decPacket_i, stall_i,
        input  stallFetch_o, instBufferReady_o, outValid_o, outPacket_o
    );

    modport slave (
        input  decValid_i, decPacket_i, stall_i,
        output stallFetch_o, instBufferReady_o, outValid_o, outPacket_o
    );
endinterface

// File: rtl/decode_inst_buffer.sv
// Multi-wide circular instruction queue between decode and rename.
// Optional IBUFF_PERF_MON_EN adds occupancy and fetch-stall-cycle monitor outputs.
module decode_inst_buffer #(
    parameter int DEPTH     = 32,
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int PKT_W     = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    decode_inst_buffer_if.slave      ib
`ifdef IBUFF_PERF_MON_EN
    ,
    output logic [$clog2(DEPTH):0]   ibuffCnt_o,
    output logic [31:0]              fetchStallCycles_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_out, n_valid, n_enq, n_deq;
    logic             stall_fetch;

    always_comb begin
        // Conservative: uses occupancy before this cycle's dequeue.
        stall_fetch = count_q > CNT_W'(DEPTH - IN_WIDTH);
        n_out       = (count_q < CNT_W'(OUT_WIDTH)) ? count_q : CNT_W'(OUT_WIDTH);
        n_valid     = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            n_valid = n_valid + CNT_W'(ib.decValid_i[i]);
        end
        n_enq   = (!stall_fetch && !flush_i) ? n_valid : '0;
        n_deq   = (!ib.stall_i && !flush_i) ? n_out : '0;
        head_d  = head_q + n_deq[PTR_W-1:0];
        tail_d  = tail_q + n_enq[PTR_W-1:0];
        count_d = count_q + n_enq - n_deq;
    end

    always_comb begin
        ib.outValid_o  = '0;
        ib.outPacket_o = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            ib.outValid_o[i]  = (CNT_W'(i) < n_out) && !flush_i;
            ib.outPacket_o[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    assign ib.instBufferReady_o = (n_out != '0) && !flush_i;
    assign ib.stallFetch_o      = stall_fetch;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; validity is tracked purely by head/count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (CNT_W'(i) < n_enq) begin
                    mem_q[tail_q + PTR_W'(i)] <= ib.decPacket_i[i];
                end
            end
        end
    end

`ifdef IBUFF_PERF_MON_EN
    logic [31:0] stall_cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cyc_q <= '0;
        end else if (stall_fetch && stall_cyc_q != '1) begin
            stall_cyc_q <= stall_cyc_q + 32'd1;
        end
    end

    assign ibuffCnt_o         = count_q;
    assign fetchStallCycles_o = stall_cyc_q;
`endif
endmodule
